// File: rtl/fifo.sv
// ---------------------------------------------------------------------------
// fifo
//   Nibble-to-byte width adapter with an 8-entry byte store, single clock.
//   Bytes are assembled from two write nibbles, low nibble first. They are
//   read out whole, in write order, on a registered byte port.
//
// Ports
//   clk            rising-edge clock for all state
//   rst            synchronous, active-high reset (priority over all activity)
//   input_valid    Data_In carries a nibble
//   input_enable   write enable; a nibble is offered when valid & enable
//   Data_In        write nibble (DIN_W bits)
//   output_valid   consumer requests a read
//   output_enable  read enable; a read is requested when valid & enable
//   Data_Out       registered read byte (DOUT_W bits), one clock read latency
// ---------------------------------------------------------------------------
module fifo #(
    parameter int DEPTH  = 8,
    parameter int DIN_W  = 4,
    parameter int DOUT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              input_valid,
    input  logic              input_enable,
    input  logic [DIN_W-1:0]  Data_In,
    input  logic              output_valid,
    input  logic              output_enable,
    output logic [DOUT_W-1:0] Data_Out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [DIN_W-1:0]  NIB_ZERO  = {DIN_W{1'b0}};
    localparam logic [DOUT_W-1:0] WORD_ZERO = {DOUT_W{1'b0}};

    logic [DOUT_W-1:0] ram_r [DEPTH];
    logic [PTR_W-1:0]  pos_write_r;
    logic [PTR_W-1:0]  pos_read_r;
    logic [CNT_W-1:0]  count_r;
    logic              writelow_r;
    logic [DIN_W-1:0]  low_nibble_r;
    logic [DOUT_W-1:0] data_out_r;

    logic              full_s;
    logic              empty_s;
    logic              wr_s;
    logic              rd_s;
    logic              commit_s;
    logic [CNT_W-1:0]  count_nxt_s;

    assign Data_Out = data_out_r;

    // Accept/commit decode; full and empty both use the pre-edge count, so a
    // read never frees space for the same cycle and there is no bypass.
    always_comb begin
        full_s   = (count_r == CNT_FULL);
        empty_s  = (count_r == CNT_ZERO);
        wr_s     = input_valid & input_enable & ~full_s;
        rd_s     = output_valid & output_enable & ~empty_s;
        commit_s = wr_s & ~writelow_r;
    end

    // Next occupancy: a commit and a read in the same cycle cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({commit_s, rd_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Nibble assembly: the low nibble is held until its high partner arrives.
    // Reset drops any pending low nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            writelow_r   <= 1'b1;
            low_nibble_r <= NIB_ZERO;
        end else if (wr_s) begin
            if (writelow_r) begin
                low_nibble_r <= Data_In;
                writelow_r   <= 1'b0;
            end else begin
                writelow_r   <= 1'b1;
            end
        end
    end

    // Byte storage: cleared on reset, written when a high nibble commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram_r[i] <= WORD_ZERO;
            end
        end else if (commit_s) begin
            ram_r[pos_write_r] <= {Data_In, low_nibble_r};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_write_r <= PTR_ZERO;
            pos_read_r  <= PTR_ZERO;
            count_r     <= CNT_ZERO;
        end else begin
            if (commit_s) begin
                pos_write_r <= pos_write_r + PTR_ONE;
            end
            if (rd_s) begin
                pos_read_r <= pos_read_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Registered read port: holds its value when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r <= WORD_ZERO;
        end else if (rd_s) begin
            data_out_r <= ram_r[pos_read_r];
        end
    end

endmodule

// File: tb/tb_fifo.sv
module tb_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       input_valid = 1'b0;
    logic       input_enable = 1'b0;
    logic [3:0] Data_In = 4'h0;
    logic       output_valid = 1'b0;
    logic       output_enable = 1'b0;
    logic [7:0] Data_Out;

    int n_cmp = 0;
    int n_err = 0;

    fifo #(.DEPTH(8), .DIN_W(4), .DOUT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .input_valid   (input_valid),
        .input_enable  (input_enable),
        .Data_In       (Data_In),
        .output_valid  (output_valid),
        .output_enable (output_enable),
        .Data_Out      (Data_Out)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; outputs sampled 1 time unit after the edge.
    task automatic cyc(input logic iv, input logic ie, input logic [3:0] d,
                       input logic ov, input logic oe, input logic r);
        input_valid   = iv;
        input_enable  = ie;
        Data_In       = d;
        output_valid  = ov;
        output_enable = oe;
        rst           = r;
        @(posedge clk);
        #1;
        input_valid   = 1'b0;
        input_enable  = 1'b0;
        Data_In       = 4'h0;
        output_valid  = 1'b0;
        output_enable = 1'b0;
        rst           = 1'b0;
    endtask

    task automatic nib(input logic [3:0] d);
        cyc(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wbyte(input logic [7:0] b);
        nib(b[3:0]);
        nib(b[7:4]);
    endtask

    task automatic rd();
        cyc(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        n_cmp++;
        assert (Data_Out === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, Data_Out, exp);
        end
    endtask

    initial begin
        logic [7:0] first8  [8];
        logic [7:0] second8 [8];
        first8  = '{8'h1E, 8'h01, 8'h02, 8'h10, 8'h33, 8'h33, 8'h33, 8'h33};
        second8 = '{8'h20, 8'h00, 8'h00, 8'h01, 8'hA5, 8'h5A, 8'hC3, 8'h3C};

        // 1: reset, then read from empty; valid without enable must not write
        cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        check("reset_dout", 8'h00);
        cyc(1'b1, 1'b0, 4'hA, 1'b1, 1'b1, 1'b0);
        check("empty_read_after_reset", 8'h00);
        cyc(1'b1, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 4'hC, 1'b1, 1'b0, 1'b0);
        rd();
        check("no_write_without_both", 8'h00);

        // 2: nibble assembly, low nibble first
        nib(4'hE); nib(4'h1);
        nib(4'h1); nib(4'h0);
        rd();
        check("assemble_1E", 8'h1E);
        rd();
        check("assemble_01", 8'h01);

        // 3: fill 4 bytes, then ten nibbles of 3 -> only four 0x33 stored
        wbyte(8'h1E); wbyte(8'h01); wbyte(8'h02); wbyte(8'h10);
        for (int i = 0; i < 10; i++) nib(4'h3);
        check("no_read_while_filling", 8'h01);

        // 4: alternate one read with one 2-nibble write; write pointer wraps
        for (int i = 0; i < 8; i++) begin
            rd();
            check($sformatf("drain_%0d", i), first8[i]);
            wbyte(second8[i]);
        end
        // full: read plus a nibble in the same cycle -> nibble dropped
        cyc(1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0);
        check("read_at_full", second8[0]);
        wbyte(8'h21);
        for (int i = 1; i < 8; i++) begin
            rd();
            check($sformatf("wrap_%0d", i), second8[i]);
        end
        rd();
        check("after_full_read", 8'h21);

        // 5: empty read holds; commit plus read while empty has no bypass
        rd();
        check("empty_hold", 8'h21);
        nib(4'h9);
        cyc(1'b1, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0);
        check("no_bypass", 8'h21);
        rd();
        check("after_commit_read", 8'h69);
        rd();
        check("empty_hold_again", 8'h69);

        // 6: reset mid-byte discards the pending low nibble
        nib(4'h5);
        cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        check("reset_mid_byte", 8'h00);
        nib(4'h7); nib(4'h0);
        rd();
        check("post_reset_byte", 8'h07);
        rd();
        check("post_reset_empty", 8'h07);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
